uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Receive-path sequencer for the UART RX.
- Detects the start-bit falling edge on the serial line and generates the per-bit oversampling edge count and bit count.
- Sequences the sampler, the start/parity/stop checkers and the serial-to-parallel de-serializer through one frame: start, Width data bits LSB first, optional parity, one stop bit.
- Issues a one-cycle data_valid when a frame completes cleanly. Sits between RX_IN and the RX datapath sub-blocks, clocked by the oversampling clock.

Parameters:
- Width, 8, data bits per frame; 5..8 legal.
- CntW, 6, width of edgecount and Prescale.

Ports:
- Clk  in  1  oversampling clock.
- Rst  in  1  asynchronous, active-high reset.
- RX_IN  in  1  serial line, idle high.
- Prescale  in  CntW  oversampling ratio; legal values 8, 16, 32; sampled only in IDLE.
- PAR_EN  in  1  parity bit present; sampled only in IDLE.
- strt_glitch  in  1  start checker result; valid while strt_chk_en=1.
- par_err  in  1  parity checker result; valid while par_chk_en=1.
- stp_err  in  1  stop checker result; valid while stp_chk_en=1.
- edgecount  out  CntW  edge index within the current bit, 0..Prescale-1.
- bitcount  out  4  bit index within the frame.
- sample_en  out  1  sampler enable.
- Deser_en  out  1  de-serializer shift qualifier.
- strt_chk_en  out  1  start check strobe.
- par_chk_en  out  1  parity check strobe.
- stp_chk_en  out  1  stop check strobe.
- data_valid  out  1  clean frame, one-cycle pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: Rst=1 asynchronously forces state IDLE; edgecount, bitcount, data_valid, busy and all enables go to 0. Reset may arrive mid-frame; no partial-frame pulse follows it.
- Latched config: Prescale and PAR_EN are captured into internal registers on the IDLE->START transition and held for the whole frame.
- Bit boundary: last_edge = (edgecount == Prescale_q-1).
- edgecount: counts 0..Prescale_q-1 in every non-IDLE state. Wraps to 0 on last_edge. Held at 0 in IDLE.
- bitcount: increments on last_edge. Reset to 0 on entry to START. Data bits are bitcount 1..Width; parity is Width+1 when PAR_EN_q=1; stop follows.
- sample_en: 1 when edgecount is in {Prescale_q/2-2, Prescale_q/2-1, Prescale_q/2} in any non-IDLE state. This gives a 3-sample majority centred on mid-bit.
- FSM states and transitions:
  - IDLE: RX_IN=0 -> START; edgecount starts at 0 the following cycle.
  - START: strt_chk_en=1 on last_edge.
    - strt_glitch=1 -> IDLE.
    - Otherwise -> DATA.
  - DATA: Deser_en=1 for the whole state. The de-serializer shifts on Deser_en && last_edge.
    - On last_edge of data bit Width: -> PARITY if PAR_EN_q, else -> STOP.
  - PARITY: par_chk_en=1 on last_edge; set internal err flag if par_err. -> STOP.
  - STOP: stp_chk_en=1 on last_edge.
    - data_valid=1 for exactly that next cycle iff !stp_err && !err flag.
    - Next state -> START if RX_IN=0 at last_edge (back-to-back frame), else -> IDLE. The err flag clears.
- Enable timing: all strobes are combinational from state/edgecount. data_valid and busy are registered.
- Simultaneous events: RX_IN falling in IDLE is ignored while Rst=1. A back-to-back start at STOP's last_edge takes priority over returning to IDLE. data_valid may coincide with the first START cycle of the next frame.
- Illegal Prescale (not 8/16/32): edgecount still wraps at Prescale_q-1. Bench does not check behaviour.

Decomposition:
- Shared package uart_rx_pkg holds:
  - State encoding constants: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4.
  - Legal prescale constants: PRESC_8, PRESC_16, PRESC_32.
- Natural sub-module: uart_rx_edge_bit_cnt. It owns edgecount/bitcount/last_edge and is driven by enable = (state != IDLE) and clear = (entering START).

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 -> Deser_en high 64 cycles; 8 shift strobes; data_valid pulses once, 1 cycle after the stop bit's last_edge (cycle 80 after start edge).
- Prescale=16, PAR_EN=1, even parity, 0x3C with correct parity bit -> par_chk_en pulses once at bitcount 9; data_valid=1.
- Same frame with par_err forced 1 -> no data_valid; FSM back in IDLE after stop bit; busy=0.
- Prescale=32: RX_IN low for 10 cycles then high, strt_glitch=1 at last_edge -> return to IDLE after 32 cycles; Deser_en never asserts.
- Two back-to-back frames 0x55, 0xAA at Prescale=8 with no idle gap -> STOP->START direct; two data_valid pulses 80 cycles apart.
- Rst asserted at DATA bitcount 4 -> all outputs 0 immediately (asynchronous). Following clean frame 0x0F -> data_valid once.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    function automatic logic presc_legal(input int p);
        return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and frame bit counter.
module uart_rx_edge_bit_cnt #(
    parameter int CntW = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            clear,
    input  logic [CntW-1:0] presc,
    output logic [CntW-1:0] edgecount,
    output logic [3:0]      bitcount,
    output logic            last_edge
);

    assign last_edge = enable && (edgecount == presc - CntW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edgecount <= '0;
            bitcount  <= '0;
        end else if (clear || !enable) begin
            edgecount <= '0;
            bitcount  <= '0;
        end else if (last_edge) begin
            edgecount <= '0;
            bitcount  <= bitcount + 4'd1;
        end else begin
            edgecount <= edgecount + CntW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, bit timing and checker strobes
// for one frame of start, data (LSB first), optional parity and stop.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int Width = 8,
    parameter int CntW  = 6
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            RX_IN,
    input  logic [CntW-1:0] Prescale,
    input  logic            PAR_EN,
    input  logic            strt_glitch,
    input  logic            par_err,
    input  logic            stp_err,
    output logic [CntW-1:0] edgecount,
    output logic [3:0]      bitcount,
    output logic            sample_en,
    output logic            Deser_en,
    output logic            strt_chk_en,
    output logic            par_chk_en,
    output logic            stp_chk_en,
    output logic            data_valid,
    output logic            busy
);

    state_t          state;
    state_t          next;
    logic [CntW-1:0] presc_q;
    logic [CntW-1:0] half;
    logic            par_en_q;
    logic            err;
    logic            enable;
    logic            clear;
    logic            last_edge;

    assign enable = (state != IDLE);

    uart_rx_edge_bit_cnt #(.CntW(CntW)) u_cnt (
        .clk       (Clk),
        .rst       (Rst),
        .enable    (enable),
        .clear     (clear),
        .presc     (presc_q),
        .edgecount (edgecount),
        .bitcount  (bitcount),
        .last_edge (last_edge)
    );

    // Three consecutive samples centred on mid-bit for majority voting
    assign half      = presc_q >> 1;
    assign sample_en = enable && ((edgecount == half - CntW'(2)) ||
                                  (edgecount == half - CntW'(1)) ||
                                  (edgecount == half));

    always_comb begin
        next        = state;
        clear       = 1'b0;
        Deser_en    = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!RX_IN) begin
                    next  = START;
                    clear = 1'b1;
                end
            end
            START: begin
                if (last_edge) begin
                    strt_chk_en = 1'b1;
                    next        = strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                Deser_en = 1'b1;
                if (last_edge && (bitcount == 4'(Width)))
                    next = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (last_edge) begin
                    par_chk_en = 1'b1;
                    next       = STOP;
                end
            end
            STOP: begin
                if (last_edge) begin
                    stp_chk_en = 1'b1;
                    // A low line here is already the next start bit
                    if (!RX_IN) begin
                        next  = START;
                        clear = 1'b1;
                    end else begin
                        next = IDLE;
                    end
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            presc_q    <= CntW'(PRESC_8);
            par_en_q   <= 1'b0;
            err        <= 1'b0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= next;
            busy       <= (next != IDLE);
            data_valid <= stp_chk_en && !stp_err && !err;
            if (state == IDLE && !RX_IN) begin
                presc_q  <= Prescale;
                par_en_q <= PAR_EN;
            end
            if (par_chk_en && par_err)
                err <= 1'b1;
            else if (stp_chk_en)
                err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: serial frames in, strobes checked.
module tb_uart_rx_ctrl;

    localparam int W  = 8;
    localparam int CW = 6;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          RX_IN;
    logic [CW-1:0] Prescale;
    logic          PAR_EN;
    logic          strt_glitch;
    logic          par_err;
    logic          stp_err;
    logic [CW-1:0] edgecount;
    logic [3:0]    bitcount;
    logic          sample_en;
    logic          Deser_en;
    logic          strt_chk_en;
    logic          par_chk_en;
    logic          stp_chk_en;
    logic          data_valid;
    logic          busy;

    uart_rx_ctrl #(.Width(W), .CntW(CW)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .edgecount   (edgecount),
        .bitcount    (bitcount),
        .sample_en   (sample_en),
        .Deser_en    (Deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid),
        .busy        (busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int data;
        int p;
        int par;
        int when;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Monitor: rebuilds the data byte from the sampling strobes and
    // checks every data_valid pulse against the scoreboard head.
    int         run = 0;
    int         dcnt = 0;
    int         scnt = 0;
    int         pcnt = 0;
    logic       prev_deser = 1'b0;
    logic [3:0] prev_bc = '0;
    logic [7:0] cap = '0;

    always @(negedge Clk) begin
        exp_t e;
        if (Rst) begin
            run        = 0;
            prev_deser = 1'b0;
        end else begin
            if (strt_chk_en) begin
                dcnt = 0;
                scnt = 0;
                pcnt = 0;
                cap  = '0;
            end
            if (sample_en) run++;
            else run = 0;
            if (Deser_en && run == 2 && bitcount >= 1 && bitcount <= 4'(W))
                cap[int'(bitcount) - 1] = RX_IN;
            if (Deser_en) dcnt++;
            if (prev_deser && bitcount != prev_bc) scnt++;
            if (par_chk_en) pcnt++;
            prev_deser = Deser_en;
            prev_bc    = bitcount;
            if (data_valid) begin
                if (sbq.size() == 0) begin
                    chk("dv_unexpected", 32'(1), 32'(0));
                end else begin
                    e = sbq.pop_front();
                    chk("dv_cycle", 32'(cyc), 32'(e.when));
                    chk("data", 32'(cap), 32'(e.data));
                    chk("deser_cycles", 32'(dcnt), 32'(e.p * W));
                    chk("shifts", 32'(scnt), 32'(W));
                    chk("par_chk", 32'(pcnt), 32'(e.par));
                end
            end
        end
    end

    function automatic logic [31:0] outs_vec();
        return 32'({edgecount, bitcount, sample_en, Deser_en, strt_chk_en,
                    par_chk_en, stp_chk_en, data_valid, busy});
    endfunction

    // gl: 0 = real start bit, else number of low cycles of a glitch.
    // abort: data bit index during which Rst is pulsed, -1 for none.
    task automatic send_frame(input logic [7:0] d, input int p,
                              input bit par, input int gl, input bit pe,
                              input bit se, input int gap, input int abort);
        int k0;
        int n;
        bit any_deser;
        Prescale = CW'(p);
        PAR_EN   = par;
        RX_IN    = 1'b0;
        k0       = cyc + 1;
        n        = W + 2 + int'(par);
        if (gl == 0 && abort < 0 && !pe && !se)
            sbq.push_back('{data: int'(d), p: p, par: int'(par),
                            when: k0 + p * n});
        @(negedge Clk);
        Prescale    = CW'(8 << $urandom_range(0, 2));
        PAR_EN      = 1'($urandom_range(0, 1));
        strt_glitch = (gl != 0);
        par_err     = pe;
        stp_err     = se;
        if (gl != 0) begin
            any_deser = 1'b0;
            repeat (gl - 1) @(negedge Clk);
            RX_IN = 1'b1;
            repeat (p + 2) begin
                @(negedge Clk);
                any_deser |= Deser_en;
            end
            chk("glitch_deser", 32'(any_deser), 32'(0));
            chk("glitch_busy", 32'(busy), 32'(0));
            strt_glitch = 1'b0;
        end else begin
            repeat (p - 1) @(negedge Clk);
            for (int i = 0; i < W; i++) begin
                RX_IN = d[i];
                if (i == abort) begin
                    repeat (p - 2) @(negedge Clk);
                    chk("abort_bitcount", 32'(bitcount), 32'(i + 1));
                    #2 Rst = 1'b1;
                    RX_IN  = 1'b1;
                    #1 chk("rst_outputs", outs_vec(), 32'(0));
                    par_err = 1'b0;
                    stp_err = 1'b0;
                    @(negedge Clk);
                    @(negedge Clk);
                    chk("rst_held", outs_vec(), 32'(0));
                    Rst = 1'b0;
                    repeat (3) @(negedge Clk);
                    return;
                end
                repeat (p) @(negedge Clk);
            end
            if (par) begin
                RX_IN = (^d) ^ pe;
                repeat (p) @(negedge Clk);
            end
            RX_IN = 1'b1;
            repeat (p) @(negedge Clk);
        end
        repeat (gap) @(negedge Clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int  pp;
        bit  ppar;
        bit  reuse;
        Rst         = 1'b1;
        RX_IN       = 1'b1;
        Prescale    = CW'(8);
        PAR_EN      = 1'b0;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        #6 chk("reset_state", outs_vec(), 32'(0));
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        repeat (2) @(negedge Clk);

        send_frame(8'hA5, 8, 1'b0, 0, 1'b0, 1'b0, 3, -1);
        send_frame(8'h3C, 16, 1'b1, 0, 1'b0, 1'b0, 3, -1);
        send_frame(8'h3C, 16, 1'b1, 0, 1'b1, 1'b0, 3, -1);
        chk("par_err_idle_busy", 32'(busy), 32'(0));
        send_frame(8'h00, 32, 1'b0, 10, 1'b0, 1'b0, 2, -1);
        send_frame(8'h55, 8, 1'b0, 0, 1'b0, 1'b0, 0, -1);
        send_frame(8'hAA, 8, 1'b0, 0, 1'b0, 1'b0, 3, -1);
        send_frame(8'hF0, 8, 1'b0, 0, 1'b0, 1'b0, 0, 3);
        send_frame(8'h0F, 8, 1'b0, 0, 1'b0, 1'b0, 3, -1);
        send_frame(8'h81, 8, 1'b0, 0, 1'b0, 1'b1, 3, -1);
        chk("stp_err_idle_busy", 32'(busy), 32'(0));

        pp    = 8;
        ppar  = 1'b0;
        reuse = 1'b0;
        for (int i = 0; i < 30; i++) begin
            int         p;
            int         g;
            int         gl;
            bit         par;
            bit         pe;
            bit         se;
            logic [7:0] d;
            if (reuse) begin
                p   = pp;
                par = ppar;
            end else begin
                p   = 8 << $urandom_range(0, 2);
                par = 1'($urandom_range(0, 1));
            end
            d  = 8'($urandom);
            gl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, p / 2) : 0;
            pe = par && ($urandom_range(0, 4) == 0);
            se = ($urandom_range(0, 5) == 0);
            g  = $urandom_range(0, 3);
            send_frame(d, p, par, gl, pe, se, g, -1);
            reuse = (gl == 0) && (g == 0);
            pp    = p;
            ppar  = par;
        end

        RX_IN = 1'b1;
        repeat (40) @(negedge Clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'(0));
        chk("final_busy", 32'(busy), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
